// File: rtl/writeback_unit.sv
// MEM/WB register and writeback into the 32x64 register file.
// Optional retire/misalign counters enabled by WB_RETIRE_CNT_EN.
module writeback_unit #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic                  mem_reg_write,
  input  logic                  mem_to_reg,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic [2:0]            mem_funct3,
  input  logic [XLEN-1:0]       alu_result,
  input  logic [XLEN-1:0]       load_data,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]       rd_data,
  output logic                  wb_valid,
  output logic                  misalign
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]      retire_count,
  output logic [15:0]           misalign_count
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_next;
  logic [REG_ADDR_W-1:0] r_rd_addr;
  logic [XLEN-1:0]       r_rd_data;
  logic                  r_mis;
  logic                  r_wq;

  logic [2:0]      w_off;
  logic [XLEN-1:0] w_sh;
  logic [XLEN-1:0] w_ext;
  logic            w_mis;
  logic            w_uns;
  logic            w_sz_b;
  logic            w_sz_h;
  logic            w_sz_w;
  logic            w_sz_d;
  logic            w_cap;
  logic            w_mis_in;
  logic            w_wq_in;
  logic [XLEN-1:0] w_wdata;

  assign w_off  = alu_result[2:0];
  assign w_sh   = load_data >> {w_off, 3'b000};
  assign w_uns  = mem_funct3[2];
  assign w_sz_b = (mem_funct3[1:0] == 2'b00);
  assign w_sz_h = (mem_funct3[1:0] == 2'b01);
  assign w_sz_w = (mem_funct3[1:0] == 2'b10);
  assign w_sz_d = (mem_funct3[1:0] == 2'b11);

  // funct3=111 falls into the doubleword group
  always_comb begin
    w_ext = w_sh;
    w_mis = 1'b0;
    unique case (1'b1)
      w_sz_b: begin
        w_ext = w_uns ? {{(XLEN-8){1'b0}}, w_sh[7:0]}
                      : {{(XLEN-8){w_sh[7]}}, w_sh[7:0]};
      end
      w_sz_h: begin
        w_ext = w_uns ? {{(XLEN-16){1'b0}}, w_sh[15:0]}
                      : {{(XLEN-16){w_sh[15]}}, w_sh[15:0]};
        w_mis = w_off[0];
      end
      w_sz_w: begin
        w_ext = w_uns ? {{(XLEN-32){1'b0}}, w_sh[31:0]}
                      : {{(XLEN-32){w_sh[31]}}, w_sh[31:0]};
        w_mis = |w_off[1:0];
      end
      w_sz_d: begin
        w_ext = load_data;
        w_mis = |w_off;
      end
      default: begin
        w_ext = load_data;
        w_mis = |w_off;
      end
    endcase
  end

  assign w_cap    = mem_valid & ~stall & ~flush;
  assign w_mis_in = mem_to_reg & w_mis;
  assign w_wq_in  = mem_reg_write & (|mem_rd_addr) & ~w_mis_in;
  assign w_wdata  = mem_to_reg ? w_ext : alu_result;

  always_comb begin
    w_next = S_IDLE;
    unique case (r_state)
      S_IDLE:  w_next = w_cap ? S_WRITE : S_IDLE;
      S_WRITE, S_HOLD: begin
        if (stall)      w_next = S_HOLD;
        else if (w_cap) w_next = S_WRITE;
        else            w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_rd_addr <= '0;
      r_rd_data <= '0;
      r_mis     <= 1'b0;
      r_wq      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_cap) begin
        r_rd_addr <= mem_rd_addr;
        r_rd_data <= w_wdata;
        r_mis     <= w_mis_in;
        r_wq      <= w_wq_in;
      end
    end
  end

  assign reg_write = (r_state == S_WRITE) & r_wq;
  assign wb_valid  = (r_state != S_IDLE);
  assign rd_addr   = r_rd_addr;
  assign rd_data   = r_rd_data;
  assign misalign  = r_mis;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_ret_cnt;
  logic [15:0]      r_mis_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ret_cnt <= '0;
      r_mis_cnt <= '0;
    end else if (r_state == S_WRITE) begin
      r_ret_cnt <= r_ret_cnt + 1'b1;
      if (r_mis && (r_mis_cnt != 16'hFFFF))
        r_mis_cnt <= r_mis_cnt + 16'd1;
    end
  end

  assign retire_count   = r_ret_cnt;
  assign misalign_count = r_mis_cnt;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed table-driven bench for writeback_unit.
// Counter checks compile in when WB_RETIRE_CNT_EN is defined.
module tb_writeback_unit;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic        mem_reg_write;
  logic        mem_to_reg;
  logic [4:0]  mem_rd_addr;
  logic [2:0]  mem_funct3;
  logic [63:0] alu_result;
  logic [63:0] load_data;
  logic        stall;
  logic        flush;
  logic        reg_write;
  logic [4:0]  rd_addr;
  logic [63:0] rd_data;
  logic        wb_valid;
  logic        misalign;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_count;
  logic [15:0] misalign_count;
`endif

  writeback_unit dut (
    .clk           (clk),
    .rst           (rst),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_to_reg    (mem_to_reg),
    .mem_rd_addr   (mem_rd_addr),
    .mem_funct3    (mem_funct3),
    .alu_result    (alu_result),
    .load_data     (load_data),
    .stall         (stall),
    .flush         (flush),
    .reg_write     (reg_write),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .wb_valid      (wb_valid),
`ifdef WB_RETIRE_CNT_EN
    .misalign      (misalign),
    .retire_count  (retire_count),
    .misalign_count(misalign_count)
`else
    .misalign      (misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic        mtr;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [63:0] alu;
    logic        e_rw;
    logic        e_mis;
    logic        chk_data;
    logic [63:0] e_data;
  } vec_t;

  localparam logic [63:0] LD = 64'h8877_6655_4433_2211;
  localparam int NV = 16;

  vec_t vec [NV];
  int total;
  int bad;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic mtr,
                       input logic [4:0] rd, input logic [2:0] f3,
                       input logic [63:0] alu);
    mem_valid     = v;
    mem_reg_write = rw;
    mem_to_reg    = mtr;
    mem_rd_addr   = rd;
    mem_funct3    = f3;
    alu_result    = alu;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int i);
    @(negedge clk);
    drive(1'b1, vec[i].rw, vec[i].mtr, vec[i].rd, vec[i].f3, vec[i].alu);
    step();
    chk($sformatf("v%0d_rw", i), {63'd0, reg_write}, {63'd0, vec[i].e_rw});
    chk($sformatf("v%0d_mis", i), {63'd0, misalign}, {63'd0, vec[i].e_mis});
    chk($sformatf("v%0d_val", i), {63'd0, wb_valid}, 64'd1);
    chk($sformatf("v%0d_rd", i), {59'd0, rd_addr}, {59'd0, vec[i].rd});
    if (vec[i].chk_data)
      chk($sformatf("v%0d_data", i), rd_data, vec[i].e_data);
    @(negedge clk);
    mem_valid = 1'b0;
    step();
    chk($sformatf("v%0d_rw_off", i), {63'd0, reg_write}, 64'd0);
    chk($sformatf("v%0d_val_off", i), {63'd0, wb_valid}, 64'd0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //          rw  mtr rd     f3      alu                    e_rw e_mis chk data
    vec[0]  = '{1, 0, 5'd5,  3'b000, 64'h1234,               1, 0, 1, 64'h1234};
    vec[1]  = '{1, 1, 5'd6,  3'b000, 64'h1007,               1, 0, 1, 64'hFFFF_FFFF_FFFF_FF88};
    vec[2]  = '{1, 1, 5'd7,  3'b101, 64'h2002,               1, 0, 1, 64'h4433};
    vec[3]  = '{1, 1, 5'd8,  3'b010, 64'h3004,               1, 0, 1, 64'hFFFF_FFFF_8877_6655};
    vec[4]  = '{1, 1, 5'd9,  3'b010, 64'h4002,               0, 1, 0, 64'h0};
    vec[5]  = '{1, 1, 5'd10, 3'b011, 64'h5000,               1, 0, 1, LD};
    vec[6]  = '{1, 1, 5'd11, 3'b111, 64'h6000,               1, 0, 1, LD};
    vec[7]  = '{1, 1, 5'd12, 3'b100, 64'h7007,               1, 0, 1, 64'h88};
    vec[8]  = '{1, 1, 5'd13, 3'b001, 64'h8006,               1, 0, 1, 64'hFFFF_FFFF_FFFF_8877};
    vec[9]  = '{1, 1, 5'd14, 3'b110, 64'h9004,               1, 0, 1, 64'h8877_6655};
    vec[10] = '{1, 0, 5'd0,  3'b000, 64'hDEAD,               0, 0, 1, 64'hDEAD};
    vec[11] = '{0, 0, 5'd3,  3'b000, 64'hBEEF,               0, 0, 1, 64'hBEEF};
    vec[12] = '{1, 1, 5'd15, 3'b011, 64'hA004,               0, 1, 0, 64'h0};
    vec[13] = '{1, 1, 5'd16, 3'b001, 64'hB001,               0, 1, 0, 64'h0};
    vec[14] = '{1, 0, 5'd17, 3'b010, 64'hC003,               1, 0, 1, 64'hC003};
    vec[15] = '{1, 1, 5'd31, 3'b000, 64'hD003,               1, 0, 1, 64'h44};

    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    load_data = LD;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 3'b000, 64'h0);
    #1 rst = 1'b0;
    #1;
    chk("rst_rw", {63'd0, reg_write}, 64'd0);
    chk("rst_rd", {59'd0, rd_addr}, 64'd0);
    chk("rst_data", rd_data, 64'd0);
    chk("rst_val", {63'd0, wb_valid}, 64'd0);
    chk("rst_mis", {63'd0, misalign}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) apply(i);

    // stall holds the entry without a second write
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 5'd4, 3'b000, 64'hAAAA);
    step();
    chk("st_w_rw", {63'd0, reg_write}, 64'd1);
    chk("st_w_data", rd_data, 64'hAAAA);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 5'd7, 3'b000, 64'h77);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("st_h%0d_rw", c), {63'd0, reg_write}, 64'd0);
      chk($sformatf("st_h%0d_val", c), {63'd0, wb_valid}, 64'd1);
      chk($sformatf("st_h%0d_data", c), rd_data, 64'hAAAA);
      chk($sformatf("st_h%0d_rd", c), {59'd0, rd_addr}, 64'd4);
    end
    @(negedge clk);
    stall = 1'b0;
    step();
    chk("st_n_rw", {63'd0, reg_write}, 64'd1);
    chk("st_n_rd", {59'd0, rd_addr}, 64'd7);
    chk("st_n_data", rd_data, 64'h77);
    // back-to-back: another capture directly from WRITE
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 5'd9, 3'b000, 64'h99);
    step();
    chk("b2b_rw", {63'd0, reg_write}, 64'd1);
    chk("b2b_data", rd_data, 64'h99);
    @(negedge clk);
    mem_valid = 1'b0;
    step();
    chk("b2b_idle", {63'd0, wb_valid}, 64'd0);

    // flush blocks capture from IDLE
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 5'd2, 3'b000, 64'h55);
    flush = 1'b1;
    step();
    chk("fl_val", {63'd0, wb_valid}, 64'd0);
    chk("fl_rw", {63'd0, reg_write}, 64'd0);
    // stall that starts in IDLE stays IDLE
    @(negedge clk);
    flush = 1'b0;
    stall = 1'b1;
    step();
    chk("si_val", {63'd0, wb_valid}, 64'd0);

    // flush+stall during WRITE: entry held, incoming killed
    @(negedge clk);
    stall = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'd3, 3'b000, 64'h33);
    step();
    chk("fs_w_rw", {63'd0, reg_write}, 64'd1);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 5'd8, 3'b000, 64'h88);
    stall = 1'b1;
    flush = 1'b1;
    step();
    chk("fs_h_val", {63'd0, wb_valid}, 64'd1);
    chk("fs_h_rw", {63'd0, reg_write}, 64'd0);
    chk("fs_h_data", rd_data, 64'h33);
    @(negedge clk);
    stall = 1'b0;
    step();
    chk("fs_i_val", {63'd0, wb_valid}, 64'd0);
    chk("fs_i_data", rd_data, 64'h33);
    @(negedge clk);
    flush = 1'b0;
    mem_valid = 1'b0;

    // asynchronous reset between edges while in WRITE
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 5'd12, 3'b000, 64'hCAFE);
    step();
    chk("ar_w_rw", {63'd0, reg_write}, 64'd1);
    mem_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("ar_rw", {63'd0, reg_write}, 64'd0);
    chk("ar_rd", {59'd0, rd_addr}, 64'd0);
    chk("ar_data", rd_data, 64'd0);
    chk("ar_val", {63'd0, wb_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

`ifdef WB_RETIRE_CNT_EN
    do_reset();
    chk("cnt_rst", {32'd0, retire_count}, 64'd0);
    for (int k = 0; k < 10; k++) apply(k == 5 ? 4 : 0);
    chk("cnt_ret", {32'd0, retire_count}, 64'd10);
    chk("cnt_mis", {48'd0, misalign_count}, 64'd1);
`else
    do_reset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
